// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-port register file with a per-register busy scoreboard.
// Combinational reads with writeback forwarding. Registered writes where the
// highest-numbered write port wins. The scoreboard lets decode detect hazards
// against writebacks that are still in flight.
// Optional build macro: REGFILE_DUMP_EN. It adds a simulation-only register
// dump that fires when halted rises. Without the macro, halted is unused.
module regfile_mp_sb #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int GP_IDX   = 28,
  parameter int SP_IDX   = 29,
  parameter int FP_IDX   = 30,
  parameter logic [DATA_W-1:0] GP_INIT = 32'h1000_8000,
  parameter logic [DATA_W-1:0] SP_INIT = 32'h7fff_fffc
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_num,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_rdy,
  input  logic [NUM_WR-1:0]        wr_we,
  input  logic [NUM_WR*ADDR_W-1:0] wr_num,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_num,
  output logic                     iss_stall,
  output logic [ADDR_W:0]          busy_cnt,
  input  logic                     halted
);

  logic [DATA_W-1:0]   mem [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] wr_clr;
  logic [NUM_REGS-1:0] busy_nxt;
  logic [ADDR_W:0]     cnt_nxt;
  logic                iss_set;
  logic [ADDR_W-1:0]   ridx;
  logic                rhit;
  logic [DATA_W-1:0]   rfwd;

  // Index 0 and indices past the end of the file are never stored or tracked.
  function automatic logic writable(input logic [ADDR_W-1:0] idx);
    return (idx != '0) && (int'(idx) < NUM_REGS);
  endfunction

  // A register is cleared when any enabled write port targets it this cycle.
  always_comb begin
    wr_clr = '0;
    for (int k = 0; k < NUM_WR; k++) begin
      if (wr_we[k] && writable(wr_num[k*ADDR_W +: ADDR_W]))
        wr_clr[wr_num[k*ADDR_W +: ADDR_W]] = 1'b1;
    end
  end

  // An issue is refused only on WAW against a busy register that no write is retiring now.
  always_comb begin
    iss_stall = iss_valid && writable(iss_num) && busy[iss_num] && !wr_clr[iss_num];
    iss_set   = iss_valid && writable(iss_num) && !iss_stall;
    busy_nxt  = busy & ~wr_clr;
    if (iss_set)
      busy_nxt[iss_num] = 1'b1;
    cnt_nxt = '0;
    for (int r = 0; r < NUM_REGS; r++)
      cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, busy_nxt[r]};
  end

  // Read ports: zero register, then forwarding from the highest writing port, then storage.
  always_comb begin
    rd_data = '0;
    rd_rdy  = '1;
    ridx    = '0;
    rhit    = 1'b0;
    rfwd    = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      ridx = rd_num[i*ADDR_W +: ADDR_W];
      rhit = 1'b0;
      rfwd = '0;
      if (writable(ridx)) begin
        for (int k = 0; k < NUM_WR; k++) begin
          if (wr_we[k] && (wr_num[k*ADDR_W +: ADDR_W] == ridx)) begin
            rhit = 1'b1;
            rfwd = wr_data[k*DATA_W +: DATA_W];
          end
        end
        if (rhit) begin
          rd_data[i*DATA_W +: DATA_W] = rfwd;
        end else begin
          rd_data[i*DATA_W +: DATA_W] = mem[ridx];
          rd_rdy[i]                   = !busy[ridx];
        end
      end
    end
  end

  // Storage and scoreboard state. Later ports overwrite earlier ones on the same index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (r == GP_IDX)
          mem[r] <= GP_INIT;
        else if ((r == SP_IDX) || (r == FP_IDX))
          mem[r] <= SP_INIT;
        else
          mem[r] <= '0;
      end
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (wr_we[k] && writable(wr_num[k*ADDR_W +: ADDR_W]))
          mem[wr_num[k*ADDR_W +: ADDR_W]] <= wr_data[k*DATA_W +: DATA_W];
      end
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

`ifdef REGFILE_DUMP_EN
  logic halted_q;

  task automatic dump_regs();
    $display("regdump at time %0t", $time);
    for (int r = 0; r < NUM_REGS; r++) begin
      $display("r%0d 0x%h %0d busy=%0b", r, mem[r], mem[r], busy[r]);
    end
  endtask

  // Dump the architectural state once on each rising edge of halted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted;
      if (halted && !halted_q)
        dump_regs();
    end
  end
`else
  logic unused_halted;
  assign unused_halted = halted;
`endif

endmodule
